store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the CPU's load-size extraction path. Accepts a store request (sw/sh/sb) from the control unit and writes the register data into data memory.
- Full-word stores write directly.
- Halfword and byte stores use a read-modify-write sequence. The low halfword or low byte of the memory word is replaced; the remaining bits are preserved.
- Sits between the register file / control unit and the synchronous data memory.

Parameters:
- MEM_LAT, 1, data memory read latency in cycles (address presented → mem_rdata valid); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe, sampled only in IDLE.
- sscontrol  input  2  store size: 0 = sw, 1 = sh, 2 = sb, 3 = invalid.
- addr  input  32  target word address.
- regData  input  32  data from the register file.
- mem_rdata  input  32  data memory read data.
- mem_addr  output  32  data memory address.
- mem_wr  output  1  data memory write enable, 1-cycle pulse.
- mem_wdata  output  32  data memory write data.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  1-cycle completion pulse.
- error  output  1  valid only with done; marks an aborted request.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE, latency counter = 0. Outputs mem_addr, mem_wdata, mem_wr, busy, done and error are all 0.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - On start = 1, latch sscontrol, addr and regData; load mem_addr with addr.
  - sscontrol = 0 → WRITE.
  - sscontrol = 1 or 2 → READ.
  - sscontrol = 3 → DONE with error = 1; no memory access.
- READ: present mem_addr for 1 cycle with mem_wr = 0; load counter = MEM_LAT; → WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture mem_rdata into the old-word register; → WRITE.
- WRITE:
  - Assert mem_wr = 1 for exactly this cycle.
  - mem_wdata by size:
    - sw: regData.
    - sh: {old[31:16], regData[15:0]}.
    - sb: {old[31:8], regData[7:0]}.
  - → DONE.
- DONE: done = 1 for one cycle, error as determined; → IDLE. A new start is accepted on the cycle after DONE, never in DONE itself.
- Latency from start accepted (cycle 0) to the done pulse:
  - sw: 2 cycles (WRITE in cycle 1).
  - sh/sb: 3 + MEM_LAT cycles. With MEM_LAT = 1: READ c1, WAIT c2, WRITE c3, DONE c4.
- start asserted while busy is ignored, and the latched request is unaffected.
- Input changes after acceptance have no effect on the operation in progress.
- mem_addr holds its last latched value outside an operation.
- mem_wr is never asserted outside WRITE.
- Reset mid-operation aborts it: no write occurs if reset lands before WRITE; no done pulse is produced.
- No byte-lane offset from addr[1:0]. Sub-word data always targets the low bits of the word, mirroring the load path.

Optional Feature:
- STORE_ALIGN_CHECK_EN defined:
  - In IDLE, sh with addr[0] = 1, or sw with addr[1:0] ≠ 0, goes directly to DONE with error = 1. No READ and no WRITE.
  - sb is never misaligned.
- Macro undefined: no alignment check; addr is used as given; error is raised only for sscontrol = 3.

Decomposition:
- Shared package (cpu_pkg):
  - store-size codes SS_SW = 2'd0, SS_SH = 2'd1, SS_SB = 2'd2, SS_BAD = 2'd3;
  - store-state enum (IDLE, READ, WAIT, WRITE, DONE).
  - The load-size codes belong in the same package for symmetry.
- One natural sub-module: store_merge.
  - Purely combinational: (size, old word, regData) → merged word.
  - Instantiated once, feeding mem_wdata.

Test Plan:
- Reset, then sw: addr = 0x40, regData = 0xDEADBEEF → mem_wr in c1 with mem_addr = 0x40 and mem_wdata = 0xDEADBEEF; done in c2; error = 0.
- sh: memory[0x44] = 0x11223344, regData = 0xAAAA5566, MEM_LAT = 1 → single write in c3 of 0x11225566; done in c4.
- sb: memory[0x48] = 0xCAFEF00D, regData = 0x000000EE, MEM_LAT = 3 → write of 0xCAFEF0EE in c5; done in c6.
- sscontrol = 3 → done with error = 1 in c1; mem_wr never asserted. start pulsed while busy during an sh is ignored: exactly one write occurs.
- Reset asserted during WAIT of an sb → all outputs 0 immediately; no mem_wr or done afterwards. A following sw completes normally.
- With STORE_ALIGN_CHECK_EN: sh at addr = 0x41 → error = 1 in c1, no memory access. Without it, the same request writes at mem_addr = 0x41.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the memory-access datapath.
//   - Store-size codes driven by the control unit (sw / sh / sb / invalid).
//   - Load-size codes with the same encoding, for the load extraction path.
//   - State encoding of the store unit sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Store-size codes (sscontrol)
  localparam logic [1:0] SS_SW  = 2'd0;
  localparam logic [1:0] SS_SH  = 2'd1;
  localparam logic [1:0] SS_SB  = 2'd2;
  localparam logic [1:0] SS_BAD = 2'd3;

  // Load-size codes, encoded the same way as the store side
  localparam logic [1:0] LS_LW  = 2'd0;
  localparam logic [1:0] LS_LH  = 2'd1;
  localparam logic [1:0] LS_LB  = 2'd2;
  localparam logic [1:0] LS_BAD = 2'd3;

  // Width of the memory-latency down-counter (covers MEM_LAT up to 7)
  localparam int unsigned LAT_CNT_W = 3;

  // Store unit sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } store_state_e;

endpackage

// File: rtl/store_merge.sv
// ---------------------------------------------------------------------------
// store_merge
// Combinational merge of register data into an existing memory word.
// Sub-word stores always target the low bits of the word.
// Ports:
//   size     in  [1:0]  store-size code (cpu_pkg SS_*)
//   old_word in  [31:0] current memory word
//   reg_data in  [31:0] register-file data
//   merged   out [31:0] word to write back
// ---------------------------------------------------------------------------
module store_merge
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] old_word,
  input  logic [31:0] reg_data,
  output logic [31:0] merged
);

  // Select which bits come from the register and which are preserved.
  always_comb begin
    merged = old_word;
    case (size)
      SS_SW:   merged = reg_data;
      SS_SH:   merged = {old_word[31:16], reg_data[15:0]};
      SS_SB:   merged = {old_word[31:8], reg_data[7:0]};
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
// Writes register data into synchronous data memory for sw / sh / sb.
// Full words are written directly; halfwords and bytes are read, merged into
// the low bits of the old word and written back.
// Optional build macro: STORE_ALIGN_CHECK_EN -- when defined, a misaligned
// sw (addr[1:0] != 0) or sh (addr[0] = 1) aborts with error, no memory access.
// Parameter:
//   MEM_LAT    memory read latency in cycles (1..7)
// Ports:
//   clk        in        clock, rising edge
//   reset      in        asynchronous active-high reset
//   start      in        request strobe, sampled only in IDLE
//   sscontrol  in  [1:0] store size (SS_SW/SS_SH/SS_SB/SS_BAD)
//   addr       in  [31:0] target word address
//   regData    in  [31:0] register-file data
//   mem_rdata  in  [31:0] memory read data
//   mem_addr   out [31:0] memory address (holds last latched value)
//   mem_wr     out       memory write enable, single-cycle pulse
//   mem_wdata  out [31:0] memory write data
//   busy       out       high whenever not IDLE
//   done       out       single-cycle completion pulse
//   error      out       with done: request was aborted
// ---------------------------------------------------------------------------
module store_unit
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sscontrol,
  input  logic [31:0] addr,
  input  logic [31:0] regData,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);

  store_state_e          state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  misalign_s;
  logic                  bad_req_s;
  logic [1:0]            merge_size_s;
  logic [31:0]           merge_old_s;
  logic [31:0]           merge_data_s;
  logic [31:0]           merge_word_s;

`ifdef STORE_ALIGN_CHECK_EN
  assign misalign_s = ((sscontrol == SS_SH) && addr[0]) ||
                      ((sscontrol == SS_SW) && (addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign bad_req_s = (sscontrol == SS_BAD) || misalign_s;

  store_merge u_merge (
    .size     (merge_size_s),
    .old_word (merge_old_s),
    .reg_data (merge_data_s),
    .merged   (merge_word_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    data_d       = data_q;
    old_d        = old_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    error_d      = 1'b0;
    // The merger sees the live request in IDLE (sw writes next cycle) and the
    // latched request otherwise.
    merge_size_s = size_q;
    merge_old_s  = old_q;
    merge_data_s = data_q;

    case (state_q)
      IDLE: begin
        merge_size_s = sscontrol;
        merge_data_s = regData;
        if (start) begin
          size_d     = sscontrol;
          data_d     = regData;
          mem_addr_d = addr;
          if (bad_req_s) begin
            state_d = DONE;
            error_d = 1'b1;
          end else if (sscontrol == SS_SW) begin
            state_d     = WRITE;
            mem_wdata_d = merge_word_s;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        cnt_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        // Merge straight from the bus so the write data is ready in WRITE.
        merge_old_s = mem_rdata;
        if (cnt_q <= LAT_CNT_W'(1)) begin
          old_d       = mem_rdata;
          mem_wdata_d = merge_word_s;
          cnt_d       = cnt_q - LAT_CNT_W'(1);
          state_d     = WRITE;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      WRITE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_wr_d = (state_d == WRITE);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= LAT_CNT_W'(0);
      size_q      <= 2'b00;
      data_q      <= 32'h0000_0000;
      old_q       <= 32'h0000_0000;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      data_q      <= data_d;
      old_q       <= old_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_store_unit.sv
// ---------------------------------------------------------------------------
// tb_store_unit
// Two store units (MEM_LAT = 1 and MEM_LAT = 3) share one request stream;
// each has its own latency-accurate memory. Directed table vectors, a reset
// abort sequence and random requests are checked against a word-level model.
// ---------------------------------------------------------------------------
module tb_store_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  sscontrol;
  logic [31:0] addr;
  logic [31:0] regData;

  logic [31:0] mem_rdata_i [2];
  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic        mem_wr_o    [2];
  logic        busy_o      [2];
  logic        done_o      [2];
  logic        error_o     [2];

  logic [31:0] mem_a   [256];
  logic [31:0] mem_b   [256];
  logic [31:0] ref_mem [256];
  logic [31:0] p1_q;
  logic [31:0] p3_q [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    bit          pre;
    logic [31:0] pre_val;
    logic [31:0] exp_word;
    bit          exp_err;
    bit          pulse_done;
  } vec_t;

  vec_t vecs [7];

  store_unit #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .sscontrol(sscontrol),
    .addr(addr), .regData(regData), .mem_rdata(mem_rdata_i[0]),
    .mem_addr(mem_addr_o[0]), .mem_wr(mem_wr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .error(error_o[0])
  );

  store_unit #(.MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start), .sscontrol(sscontrol),
    .addr(addr), .regData(regData), .mem_rdata(mem_rdata_i[1]),
    .mem_addr(mem_addr_o[1]), .mem_wr(mem_wr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .error(error_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: address registered each edge, data appears MEM_LAT edges later.
  always @(posedge clk) begin
    p1_q    <= mem_addr_o[0];
    p3_q[0] <= mem_addr_o[1];
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
  end

  assign mem_rdata_i[0] = mem_a[p1_q[7:0]];
  assign mem_rdata_i[1] = mem_b[p3_q[2][7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
    bit bad;
    bad = (sz == 2'd3);
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 2'd0 && a[1:0] != 2'd0) bad = 1'b1;
    if (sz == 2'd1 && a[0] == 1'b1) bad = 1'b1;
`endif
    return bad;
  endfunction

  // Bits of the old word that survive the store.
  function automatic logic [31:0] model_word(input logic [1:0] sz, input logic [31:0] old,
                                             input logic [31:0] d);
    logic [31:0] keep;
    keep = (sz == 2'd1) ? 32'hFFFF_0000 : (sz == 2'd2) ? 32'hFFFF_FF00 : 32'h0000_0000;
    return (old & keep) | (d & ~keep);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem_a[a[7:0]]   = v;
    mem_b[a[7:0]]   = v;
    ref_mem[a[7:0]] = v;
  endtask

  // Issue one request, watch both units for 12 cycles, compare with expectations.
  task automatic run_txn(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input bit pulse_done,
                         input logic [31:0] exp_word, input bit exp_err);
    int          wcnt [2];
    int          wcyc [2];
    int          dcnt [2];
    int          dcyc [2];
    int          bcnt [2];
    int          stray [2];
    logic [31:0] waddr [2];
    logic [31:0] wdat [2];
    logic        derr [2];
    int          lat;
    int          exp_w;
    int          exp_d;
    for (int i = 0; i < 2; i++) begin
      wcnt[i] = 0; wcyc[i] = 0; dcnt[i] = 0; dcyc[i] = 0; bcnt[i] = 0; stray[i] = 0;
      waddr[i] = 32'h0; wdat[i] = 32'h0; derr[i] = 1'b0;
    end
    @(negedge clk);
    sscontrol = sz; addr = a; regData = d; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mem_wr_o[i]) begin
          wcnt[i]++; wcyc[i] = k; waddr[i] = mem_addr_o[i]; wdat[i] = mem_wdata_o[i];
        end
        if (done_o[i]) begin
          dcnt[i]++; dcyc[i] = k; derr[i] = error_o[i];
        end
        if (busy_o[i]) bcnt[i]++;
        if (error_o[i] && !done_o[i]) stray[i]++;
      end
      // Ignored strobes while busy, with scrambled inputs after acceptance.
      start     = (k == 1) || (pulse_done && k == 2);
      sscontrol = 2'($urandom_range(0, 3));
      addr      = $urandom;
      regData   = $urandom;
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lat   = (i == 0) ? 1 : 3;
      exp_w = exp_err ? 0 : ((sz == SS_SW) ? 1 : 2 + lat);
      exp_d = exp_err ? 1 : exp_w + 1;
      chk($sformatf("%s L%0d write count", tag, lat), wcnt[i], exp_err ? 32'd0 : 32'd1);
      if (!exp_err && wcnt[i] > 0) begin
        chk($sformatf("%s L%0d write addr", tag, lat), waddr[i], a);
        chk($sformatf("%s L%0d write data", tag, lat), wdat[i], exp_word);
        chk($sformatf("%s L%0d write cycle", tag, lat), wcyc[i], exp_w);
      end
      chk($sformatf("%s L%0d done count", tag, lat), dcnt[i], 32'd1);
      chk($sformatf("%s L%0d done cycle", tag, lat), dcyc[i], exp_d);
      chk($sformatf("%s L%0d error", tag, lat), 32'(derr[i]), 32'(exp_err));
      chk($sformatf("%s L%0d busy cycles", tag, lat), bcnt[i], exp_d);
      chk($sformatf("%s L%0d error without done", tag, lat), stray[i], 32'd0);
      if (wcnt[i] > 0) begin
        if (i == 0) mem_a[waddr[i][7:0]] = wdat[i];
        else        mem_b[waddr[i][7:0]] = wdat[i];
      end
    end
    if (!exp_err) ref_mem[a[7:0]] = exp_word;
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d] mem_addr", tag, i), mem_addr_o[i], 32'h0);
      chk($sformatf("%s[%0d] mem_wdata", tag, i), mem_wdata_o[i], 32'h0);
      chk($sformatf("%s[%0d] mem_wr", tag, i), 32'(mem_wr_o[i]), 32'h0);
      chk($sformatf("%s[%0d] busy", tag, i), 32'(busy_o[i]), 32'h0);
      chk($sformatf("%s[%0d] done", tag, i), 32'(done_o[i]), 32'h0);
      chk($sformatf("%s[%0d] error", tag, i), 32'(error_o[i]), 32'h0);
    end
  endtask

  initial begin
    int nw;
    int nd;
    int mism_a;
    int mism_b;

    vecs[0] = '{SS_SW,  32'h40, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[1] = '{SS_SH,  32'h44, 32'hAAAA5566, 1'b1, 32'h11223344, 32'h11225566, 1'b0, 1'b0};
    vecs[2] = '{SS_SB,  32'h48, 32'h000000EE, 1'b1, 32'hCAFEF00D, 32'hCAFEF0EE, 1'b0, 1'b0};
    vecs[3] = '{SS_BAD, 32'h50, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[5] = '{SS_SB,  32'h43, 32'hFFFFFF01, 1'b1, 32'h89ABCDEF, 32'h89ABCD01, 1'b0, 1'b0};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[4] = '{SS_SH,  32'h41, 32'h7777ABCD, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b0};
    vecs[6] = '{SS_SW,  32'h46, 32'h13579BDF, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
`else
    vecs[4] = '{SS_SH,  32'h41, 32'h7777ABCD, 1'b1, 32'h0BADF00D, 32'h0BADABCD, 1'b0, 1'b0};
    vecs[6] = '{SS_SW,  32'h46, 32'h13579BDF, 1'b0, 32'h0,        32'h13579BDF, 1'b0, 1'b0};
`endif

    for (int j = 0; j < 256; j++) begin
      logic [31:0] v;
      v = $urandom;
      mem_a[j] = v; mem_b[j] = v; ref_mem[j] = v;
    end

    reset = 1'b1; start = 1'b0; sscontrol = 2'd0; addr = 32'h0; regData = 32'h0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre) preload(vecs[v].a, vecs[v].pre_val);
      run_txn($sformatf("vec%0d", v), vecs[v].sz, vecs[v].a, vecs[v].d,
              vecs[v].pulse_done, vecs[v].exp_word, vecs[v].exp_err);
    end

    // Reset landing in WAIT of an sb aborts both units.
    @(negedge clk);
    sscontrol = SS_SB; addr = 32'h48; regData = 32'h00000055; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_outputs_zero("reset in WAIT");
    @(negedge clk);
    reset = 1'b0;
    nw = 0; nd = 0;
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mem_wr_o[i]) nw++;
        if (done_o[i]) nd++;
      end
    end
    chk("post-abort writes", nw, 32'd0);
    chk("post-abort dones", nd, 32'd0);
    run_txn("after abort sw", SS_SW, 32'h4C, 32'h0F0F1234, 1'b0, 32'h0F0F1234, 1'b0);

    // Random requests against the word-level model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      bit          bad;
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      d   = $urandom;
      bad = model_bad(sz, a);
      run_txn($sformatf("rnd%0d", n), sz, a, d, 1'b0,
              model_word(sz, ref_mem[a[7:0]], d), bad);
    end

    mism_a = 0; mism_b = 0;
    for (int j = 0; j < 256; j++) begin
      if (mem_a[j] !== ref_mem[j]) mism_a++;
      if (mem_b[j] !== ref_mem[j]) mism_b++;
    end
    chk("memory image L1", mism_a, 32'd0);
    chk("memory image L3", mism_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
